vga_fetch_arbiter: RTL and testbench

VGA_FETCH_ARBITER -- requirements
Module: vga_fetch_arbiter

---
 rtl/vga_fetch_arbiter.sv | 152 +++++++++++++++
 tb/tb_vga_fetch_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch_arbiter.sv
// Shares one single-word memory port between display prefetch reads and drawing-client writes.
// Read data lands in a pixel FIFO feeding a registered DAC output; frame_start flushes in-flight reads.
module vga_fetch_arbiter #(
  parameter int FRAME_PIX  = 1310720,
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LOW_WM     = 16,
  parameter int MAX_OUT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              disp_enable,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_PIX);
  localparam logic [SW-1:0]     DEPTH_C   = SW'(FIFO_DEPTH);
  localparam logic [SW-1:0]     LOW_C     = SW'(LOW_WM);
  localparam logic [CW-1:0]     MAXO_C    = CW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     level, outstanding, discard;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rd_stale;
  logic [SW-1:0]     inflight_sum;
  logic              can_fetch, urgent, load_rd, load_wr;
  logic              rd_gnt, rd_live, rv_disc, rv_live, push, pop;

  assign inflight_sum = {1'b0, level} + {1'b0, outstanding};
  assign can_fetch    = (inflight_sum < DEPTH_C) && (outstanding < MAXO_C) && (fetch_addr < FRAME_END);
  assign urgent       = (inflight_sum < LOW_C) && can_fetch;
  assign rd_gnt       = (state == RD) && mem_gnt;
  // A read granted on or after a frame restart belongs to the old frame.
  assign rd_live      = rd_gnt && !rd_stale && !frame_start;
  assign rv_disc      = mem_rvalid && (discard != '0);
  assign rv_live      = mem_rvalid && (discard == '0) && (outstanding != '0);
  assign push         = rv_live && !frame_start;
  assign pop          = disp_enable && (level != '0);

  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    wr_ack  = 1'b0;
    load_rd = 1'b0;
    load_wr = 1'b0;
    case (state)
      IDLE: begin
        if (!frame_start) begin
          if (urgent) begin
            state_n = RD;
            load_rd = 1'b1;
          end else if (wr_req) begin
            state_n = WR;
            load_wr = 1'b1;
          end else if (can_fetch) begin
            state_n = RD;
            load_rd = 1'b1;
          end
        end
      end
      RD: begin
        mem_req = 1'b1;
        if (mem_gnt) state_n = IDLE;
      end
      WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt) begin
          wr_ack  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      outstanding <= '0;
      discard     <= '0;
      fetch_addr  <= '0;
      rd_stale    <= 1'b0;
      pix_data    <= '0;
      underflow   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state <= state_n;
      if (frame_start) begin
        fetch_addr  <= '0;
        outstanding <= '0;
        discard     <= discard + outstanding + CW'(rd_gnt) - CW'(rv_disc) - CW'(rv_live);
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        level       <= '0;
      end else begin
        if (rd_live) fetch_addr <= fetch_addr + ADDR_W'(1);
        outstanding <= outstanding + CW'(rd_live) - CW'(rv_live);
        discard     <= discard + CW'(rd_gnt && rd_stale) - CW'(rv_disc);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        level <= level + CW'(push) - CW'(pop);
      end

      if (rd_gnt) rd_stale <= 1'b0;
      else if ((state == RD) && frame_start) rd_stale <= 1'b1;

      if (disp_enable) begin
        pix_data <= (level != '0) ? fifo_mem[rd_ptr] : '0;
        if (level == '0) underflow <= 1'b1;
      end

      // Request fields are captured once so they stay stable until granted.
      if (load_rd) begin
        mem_addr <= fetch_addr;
      end else if (load_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Directed bench for vga_fetch_arbiter with an in-order memory model (read latency 2 cycles).
module tb_vga_fetch_arbiter;
  localparam int FP = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        disp_enable = 1'b0;
  logic [15:0] pix_data;
  logic        underflow;
  logic        wr_req = 1'b0;
  logic [20:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        mem_req, mem_we;
  logic [20:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  logic        rv_hold = 1'b0;
  logic [20:0] rq_addr[$];
  int          rq_stamp[$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [20:0] last_rd_addr = '0;
  logic [20:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;

  vga_fetch_arbiter #(.FRAME_PIX(FP)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .disp_enable(disp_enable),
    .pix_data(pix_data), .underflow(underflow),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix_of(input logic [20:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  // Memory: reads return in order one cycle after the edge following acceptance.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (!rv_hold && rq_addr.size() > 0 && cyc > rq_stamp[0]) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= pix_of(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_stamp.pop_front());
    end
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= mem_addr;
        last_wr_data <= mem_wdata;
      end else begin
        rq_addr.push_back(mem_addr);
        rq_stamp.push_back(cyc);
        rd_cnt       <= rd_cnt + 1;
        last_rd_addr <= mem_addr;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL reset_wr_ack: got %b expected 0", wr_ack); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    tests++; if (pix_data !== 16'h0) begin fails++; $display("FAIL reset_pix_data: got %h expected 0", pix_data); end
    tests++; if (mem_addr !== 21'h0 || mem_wdata !== 16'h0) begin
      fails++; $display("FAIL reset_mem_bus: got addr %h data %h expected 0 0", mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_prefetch();
    int base, exp_a, errs;
    mem_gnt = 1'b1;
    base = rd_cnt; exp_a = 0; errs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_req && mem_gnt && !mem_we) begin
        if (int'(mem_addr) != exp_a) errs++;
        exp_a++;
      end
    end
    tests++; if (rd_cnt - base != 64) begin fails++; $display("FAIL prefetch_count: got %0d expected 64", rd_cnt - base); end
    tests++; if (errs != 0) begin fails++; $display("FAIL prefetch_addr_seq: got %0d out-of-order expected 0", errs); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL prefetch_idle_req: got %b expected 0", mem_req); end
    tests++; if (wr_cnt != 0) begin fails++; $display("FAIL prefetch_no_write: got %0d expected 0", wr_cnt); end
  endtask

  task automatic test_pop();
    disp_enable = 1'b1;
    @(negedge clk);
    tests++; if (pix_data !== pix_of(21'd0)) begin fails++; $display("FAIL pop_first: got %h expected %h", pix_data, pix_of(21'd0)); end
    @(negedge clk);
    tests++; if (pix_data !== pix_of(21'd1)) begin fails++; $display("FAIL pop_second: got %h expected %h", pix_data, pix_of(21'd1)); end
    disp_enable = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (pix_data !== pix_of(21'd1)) begin fails++; $display("FAIL pop_hold: got %h expected %h", pix_data, pix_of(21'd1)); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL pop_no_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_priority();
    int base, wbase, got, acks;
    bit seen;
    mem_gnt = 1'b1; wbase = wr_cnt;
    wr_addr = 21'h0ABCD; wr_data = 16'hBEEF; wr_req = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; base = rd_cnt; seen = 1'b0; got = -1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (wr_ack) begin seen = 1'b1; got = rd_cnt - base; wr_req = 1'b0; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL prio_ack_seen: got no wr_ack expected one within 100 cycles"); end
    tests++; if (got != 16) begin fails++; $display("FAIL prio_reads_first: got %0d reads expected 16", got); end
    acks = 0;
    repeat (10) begin @(negedge clk); if (wr_ack) acks++; end
    tests++; if (acks != 0) begin fails++; $display("FAIL prio_ack_pulse: got %0d extra acks expected 0", acks); end
    tests++; if (wr_cnt - wbase != 1) begin fails++; $display("FAIL prio_write_count: got %0d expected 1", wr_cnt - wbase); end
    tests++; if (last_wr_addr !== 21'h0ABCD || last_wr_data !== 16'hBEEF) begin
      fails++; $display("FAIL prio_write_bus: got %h/%h expected 0abcd/beef", last_wr_addr, last_wr_data);
    end
  endtask

  task automatic test_frame_restart();
    int base;
    bit hit;
    logic [20:0] first_a;
    mem_gnt = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; mem_gnt = 1'b0;
    repeat (12) @(negedge clk);
    rv_hold = 1'b1; mem_gnt = 1'b1; base = rd_cnt; hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (rd_cnt - base == 5) hit = 1'b1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL restart_inflight: got %0d reads expected 5", rd_cnt - base); end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; rv_hold = 1'b0; hit = 1'b0; first_a = '1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (mem_req && mem_gnt && !mem_we) begin hit = 1'b1; first_a = mem_addr; end
    end
    tests++; if (first_a !== 21'd0) begin fails++; $display("FAIL restart_first_addr: got %h expected 0", first_a); end
    repeat (40) @(negedge clk);
    disp_enable = 1'b1;
    @(negedge clk);
    tests++; if (pix_data !== pix_of(21'd0)) begin fails++; $display("FAIL restart_pix0: got %h expected %h", pix_data, pix_of(21'd0)); end
    @(negedge clk);
    tests++; if (pix_data !== pix_of(21'd1)) begin fails++; $display("FAIL restart_pix1: got %h expected %h", pix_data, pix_of(21'd1)); end
    disp_enable = 1'b0;

    // Restart while a read at address 3 waits for its grant.
    mem_gnt = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; base = rd_cnt; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (rd_cnt - base == 3) hit = 1'b1;
    end
    mem_gnt = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 21'd3) begin
      fails++; $display("FAIL pending_rd: got req %b addr %h expected 1 3", mem_req, mem_addr);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 21'd3) begin
      fails++; $display("FAIL pending_stable: got req %b addr %h expected 1 3", mem_req, mem_addr);
    end
    repeat (10) @(negedge clk);
    mem_gnt = 1'b1;
    repeat (40) @(negedge clk);
    disp_enable = 1'b1;
    @(negedge clk);
    tests++; if (pix_data !== pix_of(21'd0)) begin fails++; $display("FAIL pending_discard: got %h expected %h", pix_data, pix_of(21'd0)); end
    disp_enable = 1'b0;
  endtask

  task automatic test_end_of_frame();
    int base, wbase;
    bit seen;
    mem_gnt = 1'b1; disp_enable = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0; base = rd_cnt;
    repeat (400) @(negedge clk);
    tests++; if (rd_cnt - base != FP) begin fails++; $display("FAIL eof_read_count: got %0d expected %0d", rd_cnt - base, FP); end
    tests++; if (last_rd_addr !== 21'd99) begin fails++; $display("FAIL eof_last_addr: got %0d expected 99", last_rd_addr); end
    wbase = wr_cnt; wr_addr = 21'h00123; wr_data = 16'h5A5A; wr_req = 1'b1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_ack) begin seen = 1'b1; wr_req = 1'b0; end
    end
    wr_req = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (!seen || wr_cnt - wbase != 1) begin fails++; $display("FAIL eof_write: got %0d writes expected 1", wr_cnt - wbase); end
    tests++; if (last_wr_addr !== 21'h00123 || last_wr_data !== 16'h5A5A) begin
      fails++; $display("FAIL eof_write_bus: got %h/%h expected 00123/5a5a", last_wr_addr, last_wr_data);
    end
    tests++; if (rd_cnt - base != FP) begin fails++; $display("FAIL eof_no_more_reads: got %0d expected %0d", rd_cnt - base, FP); end
    disp_enable = 1'b0;
  endtask

  task automatic test_reset_mid_wr();
    int wbase, acks;
    bit seen;
    mem_gnt = 1'b0; wbase = wr_cnt; acks = 0; seen = 1'b0;
    wr_addr = 21'h1F00F; wr_data = 16'hC0DE; wr_req = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (wr_ack) acks++;
      if (mem_req && mem_we) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL rstwr_pending: got no write request expected one"); end
    rst = 1'b1;
    @(negedge clk);
    if (wr_ack) acks++;
    tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL rstwr_req_drop: got req %b we %b expected 0 0", mem_req, mem_we); end
    tests++; if (mem_addr !== 21'h0 || mem_wdata !== 16'h0 || pix_data !== 16'h0) begin
      fails++; $display("FAIL rstwr_outputs: got %h %h %h expected 0 0 0", mem_addr, mem_wdata, pix_data);
    end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL rstwr_underflow: got %b expected 0", underflow); end
    wr_req = 1'b0; rst = 1'b0;
    tests++; if (acks != 0 || wr_cnt != wbase) begin fails++; $display("FAIL rstwr_no_ack: got %0d acks %0d writes expected 0 0", acks, wr_cnt - wbase); end
  endtask

  task automatic test_underflow();
    int base;
    bit hit;
    mem_gnt = 1'b1; base = rd_cnt; hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (rd_cnt - base == 1) hit = 1'b1;
    end
    mem_gnt = 1'b0;
    repeat (6) @(negedge clk);
    disp_enable = 1'b1;
    @(negedge clk);
    tests++; if (pix_data !== 16'hA5A5 || underflow !== 1'b0) begin
      fails++; $display("FAIL uf_last_word: got %h uf %b expected a5a5 0", pix_data, underflow);
    end
    @(negedge clk);
    disp_enable = 1'b0;
    tests++; if (pix_data !== 16'h0 || underflow !== 1'b1) begin
      fails++; $display("FAIL uf_empty_pop: got %h uf %b expected 0 1", pix_data, underflow);
    end
    repeat (5) @(negedge clk);
    tests++; if (pix_data !== 16'h0 || underflow !== 1'b1) begin
      fails++; $display("FAIL uf_sticky: got %h uf %b expected 0 1", pix_data, underflow);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL uf_cleared: got %b expected 0", underflow); end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_pop();
    test_priority();
    test_frame_restart();
    test_end_of_frame();
    test_reset_mid_wr();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
